// File: rtl/y86_regfile_sb.sv
// Y86 register file with two write ports, two combinational read ports,
// optional write-to-read forwarding and a per-register pending scoreboard.
module y86_regfile_sb #(
    parameter int          DATA_W   = 64,
    parameter int          NUM_REGS = 15,
    parameter logic [63:0] RSP_INIT = 64'h200,
    parameter int          BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        srcA,
    input  logic [3:0]        srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    input  logic              wr_en,
    input  logic [3:0]        dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic [3:0]        dstM,
    input  logic [DATA_W-1:0] valM,
    input  logic              rsv_en,
    input  logic [3:0]        rsv_reg,
    output logic              busyA,
    output logic              busyB,
    output logic [DATA_W-1:0] rsp_out
);

    localparam logic [4:0]        NREGS_W = 5'(NUM_REGS);
    localparam logic [DATA_W-1:0] RSP_RST = DATA_W'(RSP_INIT);
    localparam bit                FWD     = (BYPASS != 0);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic we_e, we_m;

    // RNONE (4'hF) and anything beyond the implemented registers are not addressable.
    function automatic logic idx_ok(input logic [3:0] r);
        return (r != 4'hF) && ({1'b0, r} < NREGS_W);
    endfunction

    function automatic logic [DATA_W-1:0] arr_rd(input logic [3:0] s);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (s == 4'(i)) r = regs_q[i];
        return r;
    endfunction

    function automatic logic pend_rd(input logic [3:0] s);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_REGS; i++)
            if (s == 4'(i)) r = pend_q[i];
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] rd_port(input logic [3:0] s);
        logic [DATA_W-1:0] r;
        r = '0;
        if (idx_ok(s)) begin
            if (FWD && we_m && dstM == s)      r = valM;
            else if (FWD && we_e && dstE == s) r = valE;
            else                               r = arr_rd(s);
        end
        return r;
    endfunction

    function automatic logic busy_port(input logic [3:0] s);
        logic hit;
        hit = (we_m && dstM == s) || (we_e && dstE == s);
        return idx_ok(s) && pend_rd(s) && !(FWD && hit);
    endfunction

    assign we_e = wr_en && idx_ok(dstE);
    assign we_m = wr_en && idx_ok(dstM);

    // Port M is applied after port E so it wins when both target one register.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (we_e && dstE == 4'(i)) begin
                regs_d[i] = valE;
                pend_d[i] = 1'b0;
            end
            if (we_m && dstM == 4'(i)) begin
                regs_d[i] = valM;
                pend_d[i] = 1'b0;
            end
            if (rsv_en && idx_ok(rsv_reg) && rsv_reg == 4'(i))
                pend_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= (i == 4) ? RSP_RST : '0;
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        valA  = rd_port(srcA);
        valB  = rd_port(srcB);
        busyA = busy_port(srcA);
        busyB = busy_port(srcB);
    end

    generate
        if (NUM_REGS > 4) begin : g_rsp
            assign rsp_out = regs_q[4];
        end else begin : g_no_rsp
            assign rsp_out = '0;
        end
    endgenerate

endmodule

// File: doc/y86_regfile_sb.md
Y86_REGFILE_SB -- requirements
Module: y86_regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 64, register data width.
REQ-002 SHALL have parameter NUM_REGS, default 15, architectural registers (legal 1..15, index 4'hF reserved as RNONE).
REQ-003 SHALL have parameter RSP_INIT, default 64'h200, reset value of register 4 (%rsp), truncated to DATA_W.
REQ-004 SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-005 SHALL have one clock and a synchronous, active-high reset, with ports as follows.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 srcA, srcB  in  4 each  read register indices.
REQ-009 valA, valB  out  DATA_W each  read data.
REQ-010 wr_en  in  1  write-back enable for both write ports.
REQ-011 dstE / valE  in  4 / DATA_W  execute-result write port.
REQ-012 dstM / valM  in  4 / DATA_W  memory-result write port.
REQ-013 rsv_en / rsv_reg  in  1 / 4  scoreboard reservation request.
REQ-014 busyA, busyB  out  1 each  source has a pending, unwritten result.
REQ-015 rsp_out  out  DATA_W  current content of register 4.

Function
REQ-016 Register array and pending bits SHALL update only on rising clk.
REQ-017 A port write SHALL occur when wr_en=1, dst!=4'hF and dst<NUM_REGS; otherwise it SHALL be ignored.
REQ-018 When dstE==dstM and both are valid, valM SHALL be written and valE discarded (popq %rsp rule).
REQ-019 Reads SHALL be combinational; a src of 4'hF or >=NUM_REGS SHALL return 0.
REQ-020 With BYPASS=1, a read SHALL return valM if src matches a valid dstM this cycle, else valE if it matches a valid dstE, else array content.
REQ-021 With BYPASS=0, reads SHALL return array content only; a new value SHALL be visible from the cycle after the write.
REQ-022 rsv_en=1 with a valid rsv_reg SHALL set pending[rsv_reg] at the next edge.
REQ-023 A committed write SHALL clear pending[dst] at the next edge.
REQ-024 Simultaneous reserve and write to the same register SHALL leave pending set (reserve wins).
REQ-025 busyX SHALL equal pending[srcX]; with BYPASS=1 it SHALL be 0 when srcX is being written this cycle; it SHALL be 0 for RNONE or out-of-range src.
REQ-026 rsp_out SHALL follow register 4 with no bypass; with NUM_REGS<=4 it SHALL be 0.
REQ-027 Arithmetic SHALL be none; data SHALL be stored without modification, width DATA_W.

Reset
REQ-028 reset=1 at a rising edge SHALL set all registers to 0 except register 4 = RSP_INIT, and clear all pending bits.
REQ-029 reset SHALL dominate any write or reservation in the same cycle.
REQ-030 While reset is held, reads SHALL reflect post-reset contents (BYPASS forwarding is still combinationally active on inputs; benches drive wr_en=0 during reset).

Verification
REQ-031 Reset, srcA=4, srcB=0 -> valA=64'h200, valB=0, busyA=busyB=0, rsp_out=64'h200.
REQ-032 wr_en=1, dstE=1, valE=5, srcA=1, BYPASS=1 -> valA=5 in the same cycle; BYPASS=0 -> valA=0 that cycle and 5 the next.
REQ-033 wr_en=1, dstE=4, valE=64'h1F8, dstM=4, valM=64'h77 -> rsp_out=64'h77 after the edge.
REQ-034 rsv_en=1, rsv_reg=3, then srcA=3 -> busyA=1; later wr_en=1, dstM=3, valM=9 -> busyA=0 same cycle (BYPASS=1), pending cleared after edge.
REQ-035 Same cycle rsv_reg=2 and dstE=2 write of 6 -> register 2=6, busy for src 2 remains 1 next cycle.
REQ-036 Reservation on reg 5 plus write of 8 to reg 6, then reset mid-operation -> reg 6=0, all busy=0, rsp_out=64'h200.
